cpu_6502_interrupt_ctrl: RTL and testbench
==========================================

// Module: cpu_6502_interrupt_ctrl
// PURPOSE
//  Request side of the microcode sequencer's interrupt/init handshake: drives o_init and o_handle_irq into the
//  sequencer and supplies the vector address and pushed-B value for the sequence it starts.
//  - Synchronises the IRQ/NMI pins, edge-detects NMI and level-qualifies IRQ with the I flag.
//  - Arbitrates at instruction boundaries and tracks each service sequence until the sequencer signals it is done.
// PARAMETERS
//  SYNC_STAGES  2        pin synchroniser depth (>=2)
//  VEC_NMI      16'hFFFA NMI vector address
//  VEC_RES      16'hFFFC reset vector address
//  VEC_IRQ      16'hFFFE IRQ/BRK vector address
// PORTS
//  i_clk          in   1   single clock; all state on rising edge
//  i_rst_n        in   1   asynchronous active-low reset
//  i_irq_n        in   1   IRQ pin, level, asynchronous
//  i_nmi_n        in   1   NMI pin, falling-edge, asynchronous
//  i_i_flag       in   1   status register I bit (1 = IRQ masked)
//  i_seq_start    in   1   sequencer in START (instruction boundary) this cycle
//  i_brk          in   1   opcode at this boundary is BRK
//  i_vector_load  in   1   sequencer in LOAD_VECTOR this cycle (vector sampled here)
//  i_seq_done     in   1   sequencer in MICRO_EXECUTE of an init/irq/BRK sequence
//  o_init         out  1   reset-vector sequence active
//  o_handle_irq   out  1   hardware-interrupt sequence active
//  o_vector       out  16  vector address for LOAD_VECTOR/READ_VECTOR_HI
//  o_b_flag       out  1   B bit value for the WRITE_SR push
//  o_nmi_pending  out  1   latched, unserviced NMI edge
// BEHAVIOUR
//  Reset values (async, held while i_rst_n=0): o_init=1, o_handle_irq=0, o_vector=VEC_RES, o_b_flag=0,
//   o_nmi_pending=0, synchroniser flops=1, FSM=ST_INIT.
//  Synchronisers: SYNC_STAGES flops per pin; nmi_s/irq_s are the last stage, so pin-to-use latency is SYNC_STAGES cycles.
//  NMI edge: nmi_s_prev & ~nmi_s sets nmi_pending the following cycle.
//   Cleared in the cycle i_vector_load samples VEC_NMI.
//   A new edge in that same cycle wins: pending stays 1.
//  irq_req = ~irq_s & ~i_i_flag. Not latched: IRQ deasserted before a boundary is lost.
//  FSM (one-hot-able; 3 states):
//   ST_INIT: o_init=1, o_vector=VEC_RES.
//    i_vector_load -> vector latched; remain until i_seq_done -> ST_IDLE (o_init=0 next cycle).
//    NMI edges during ST_INIT are discarded.
//   ST_IDLE, evaluated when i_seq_start=1; priority NMI > IRQ > BRK:
//    nmi_pending -> take: src=NMI, vector=VEC_NMI, b=0.
//    else irq_req -> take: src=IRQ, vector=VEC_IRQ, b=0.
//    else i_brk -> ST_SERVICE, vector=VEC_IRQ, b=1, o_handle_irq stays 0 (BRK runs its own microcode).
//    take: o_handle_irq driven 1 combinationally in the same cycle (Mealy), then registered; -> ST_SERVICE.
//   ST_SERVICE: o_handle_irq held for hardware sources.
//    i_seq_done -> ST_IDLE; o_handle_irq=0 and o_b_flag=0 the next cycle.
//    i_seq_start without i_seq_done is a protocol error: state unchanged.
//  Vector lock: o_vector freezes in the i_vector_load cycle; later NMI edges only set pending.
//  Simultaneous i_seq_done and i_seq_start: done processed first, boundary then evaluated as in ST_IDLE.
//  I flag change during ST_SERVICE has no effect on the active sequence.
//  Reset mid-sequence: immediate return to reset values; the sequencer restarts via o_init.
// CONFIGURATION
//  CPU_6502_NMI_HIJACK_EN defined:
//   NMI edge in ST_SERVICE (IRQ or BRK) before i_vector_load switches o_vector to VEC_NMI.
//   That NMI is consumed at vector load; o_b_flag is unchanged (BRK hijack still pushes B=1).
//  CPU_6502_NMI_HIJACK_EN undefined:
//   vector fixed at service entry; NMI stays pending and is taken at the next boundary.
// TESTING
//  1 Release reset -> o_init=1, o_vector=FFFC; vector_load then seq_done -> o_init=0, ST_IDLE.
//  2 irq_n=0, I=0, seq_start -> o_handle_irq=1 same cycle, o_vector=FFFE, b=0; I=1 at boundary -> no service.
//  3 NMI falling edge (pulse 1 cycle) -> o_nmi_pending=1 after SYNC_STAGES+1; boundary -> o_vector=FFFA, pending clears at vector_load.
//  4 NMI edge and irq_n=0 at same boundary -> NMI taken first; IRQ taken at following boundary.
//  5 BRK boundary, NMI edge before vector_load -> HIJACK_EN: o_vector=FFFA, b=1; else FFFE, NMI next boundary.
//  6 Assert i_rst_n=0 mid IRQ service -> outputs to reset values asynchronously, pending NMI dropped.

Source files
------------

// File: rtl/cpu_6502_interrupt_ctrl.sv
// Interrupt/init request side of the 6502 microcode sequencer handshake: pin sync, NMI edge latch,
// boundary arbitration (NMI > IRQ > BRK) and vector/B selection. Optional: CPU_6502_NMI_HIJACK_EN.
module cpu_6502_interrupt_ctrl #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_NMI     = 16'hFFFA,
    parameter logic [15:0] VEC_RES     = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ     = 16'hFFFE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_irq_n,
    input  logic        i_nmi_n,
    input  logic        i_i_flag,
    input  logic        i_seq_start,
    input  logic        i_brk,
    input  logic        i_vector_load,
    input  logic        i_seq_done,
    output logic        o_init,
    output logic        o_handle_irq,
    output logic [15:0] o_vector,
    output logic        o_b_flag,
    output logic        o_nmi_pending
);

`ifdef CPU_6502_NMI_HIJACK_EN
    localparam bit HIJACK = 1'b1;
`else
    localparam bit HIJACK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] irq_sync_reg;
    logic [SYNC_STAGES-1:0] nmi_sync_reg;
    logic                   nmi_prev_reg;

    logic        pending_reg, pending_next;
    logic        handle_reg, handle_next;
    logic        b_reg, b_next;
    logic        locked_reg, locked_next;
    logic [15:0] vector_reg, vector_next;

    logic irq_s, nmi_s, nmi_edge, irq_req;
    logic eval, take_nmi, take_irq, take_brk, go, take;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_sync_reg <= '1;
            nmi_sync_reg <= '1;
            nmi_prev_reg <= 1'b1;
        end else begin
            irq_sync_reg <= {irq_sync_reg[SYNC_STAGES-2:0], i_irq_n};
            nmi_sync_reg <= {nmi_sync_reg[SYNC_STAGES-2:0], i_nmi_n};
            nmi_prev_reg <= nmi_s;
        end
    end

    assign irq_s    = irq_sync_reg[SYNC_STAGES-1];
    assign nmi_s    = nmi_sync_reg[SYNC_STAGES-1];
    assign nmi_edge = nmi_prev_reg & ~nmi_s;
    assign irq_req  = ~irq_s & ~i_i_flag;

    // A boundary is evaluated in IDLE, or in SERVICE when done retires the old sequence first.
    assign eval     = i_seq_start & ((state_reg == ST_IDLE) |
                                     ((state_reg == ST_SERVICE) & i_seq_done));
    assign take_nmi = eval & pending_reg;
    assign take_irq = eval & ~pending_reg & irq_req;
    assign take_brk = eval & ~pending_reg & ~irq_req & i_brk;
    assign go       = take_nmi | take_irq | take_brk;
    assign take     = take_nmi | take_irq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_INIT;
            pending_reg <= 1'b0;
            handle_reg  <= 1'b0;
            b_reg       <= 1'b0;
            locked_reg  <= 1'b0;
            vector_reg  <= VEC_RES;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            handle_reg  <= handle_next;
            b_reg       <= b_next;
            locked_reg  <= locked_next;
            vector_reg  <= vector_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        handle_next  = handle_reg;
        b_next       = b_reg;
        locked_next  = locked_reg;
        vector_next  = vector_reg;
        o_vector     = vector_reg;

        if (take_nmi) begin
            o_vector = VEC_NMI;
        end else if (take_irq | take_brk) begin
            o_vector = VEC_IRQ;
        end else if (HIJACK && (state_reg == ST_SERVICE) && !locked_reg && pending_reg) begin
            o_vector = VEC_NMI;
        end

        if (go) begin
            locked_next = 1'b0;
        end else if (i_vector_load) begin
            locked_next = 1'b1;
        end

        if (state_reg == ST_INIT) begin
            pending_next = 1'b0;
            vector_next  = VEC_RES;
            if (i_seq_done) begin
                state_next = ST_IDLE;
            end
        end else begin
            // A fresh edge in the clearing cycle keeps the request alive.
            pending_next = nmi_edge |
                           (pending_reg & ~(i_vector_load & (o_vector == VEC_NMI)));
            vector_next  = o_vector;
            if (eval) begin
                handle_next = take;
                b_next      = take_brk;
                state_next  = go ? ST_SERVICE : ST_IDLE;
            end else if ((state_reg == ST_SERVICE) && i_seq_done) begin
                handle_next = 1'b0;
                b_next      = 1'b0;
                state_next  = ST_IDLE;
            end
        end
    end

    assign o_init        = (state_reg == ST_INIT);
    assign o_handle_irq  = handle_reg | take;
    assign o_b_flag      = b_reg;
    assign o_nmi_pending = pending_reg;

endmodule

// File: tb/tb_cpu_6502_interrupt_ctrl.sv
// Self-checking bench for cpu_6502_interrupt_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a source-level behavioural model.
module tb_cpu_6502_interrupt_ctrl;

    localparam int          SYNC    = 2;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RES = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;
`ifdef CPU_6502_NMI_HIJACK_EN
    localparam bit HIJ = 1'b1;
`else
    localparam bit HIJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        irq_n = 1'b1, nmi_n = 1'b1, i_flag = 1'b1;
    logic        seq_start = 1'b0, brk = 1'b0, vector_load = 1'b0, seq_done = 1'b0;
    logic        init, handle_irq, b_flag, nmi_pending;
    logic [15:0] vector;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_6502_interrupt_ctrl #(
        .SYNC_STAGES(SYNC), .VEC_NMI(VEC_NMI), .VEC_RES(VEC_RES), .VEC_IRQ(VEC_IRQ)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq_n(irq_n), .i_nmi_n(nmi_n), .i_i_flag(i_flag),
        .i_seq_start(seq_start), .i_brk(brk), .i_vector_load(vector_load), .i_seq_done(seq_done),
        .o_init(init), .o_handle_irq(handle_irq), .o_vector(vector), .o_b_flag(b_flag),
        .o_nmi_pending(nmi_pending)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] vec_of(input int s);
        return (s == 1) ? VEC_NMI : VEC_IRQ;
    endfunction

    // Model: active source (0 none, 1 NMI, 2 IRQ, 3 BRK), pins seen through a SYNC-cycle delay line.
    bit          m_init;
    int          m_src;
    bit          m_pend;
    bit          m_locked;
    logic [15:0] m_vec;
    bit          nmi_q[$];
    bit          irq_q[$];

    always @(negedge clk) begin
        bit          edge_seen, irq_req, in_service, eval, go;
        int          pick;
        logic [15:0] e_vec;
        logic        e_handle;
        if (!rst_n) begin
            chk("rst_init", {15'd0, init}, 16'd1);
            chk("rst_handle", {15'd0, handle_irq}, 16'd0);
            chk("rst_vector", vector, VEC_RES);
            chk("rst_b", {15'd0, b_flag}, 16'd0);
            chk("rst_pend", {15'd0, nmi_pending}, 16'd0);
            m_init = 1; m_src = 0; m_pend = 0; m_locked = 0; m_vec = VEC_RES;
            nmi_q.delete(); irq_q.delete();
            for (int i = 0; i <= SYNC; i++) begin
                nmi_q.push_back(1'b1);
                irq_q.push_back(1'b1);
            end
        end else begin
            edge_seen  = nmi_q[0] && !nmi_q[1];
            irq_req    = !irq_q[1] && !i_flag;
            in_service = !m_init && (m_src != 0);
            eval       = seq_start && !m_init && ((m_src == 0) || seq_done);
            pick       = m_pend ? 1 : irq_req ? 2 : brk ? 3 : 0;
            go         = eval && (pick != 0);
            e_handle   = (in_service && (m_src != 3)) || (go && (pick != 3));
            if (m_init)
                e_vec = VEC_RES;
            else if (go)
                e_vec = vec_of(pick);
            else if (HIJ && in_service && !m_locked && m_pend)
                e_vec = VEC_NMI;
            else
                e_vec = m_vec;

            chk("init", {15'd0, init}, {15'd0, m_init});
            chk("handle_irq", {15'd0, handle_irq}, {15'd0, e_handle});
            chk("vector", vector, e_vec);
            chk("b_flag", {15'd0, b_flag}, {15'd0, in_service && (m_src == 3)});
            chk("nmi_pending", {15'd0, nmi_pending}, {15'd0, m_pend});

            if (m_init) begin
                m_pend = 0;
                if (seq_done) m_init = 0;
            end else begin
                m_pend = edge_seen || (m_pend && !(vector_load && (e_vec == VEC_NMI)));
                m_vec  = e_vec;
            end
            if (go) begin
                m_src = pick;
                m_locked = 0;
            end else begin
                if (in_service && seq_done) m_src = 0;
                if (vector_load) m_locked = 1;
            end
            nmi_q.push_back(nmi_n); void'(nmi_q.pop_front());
            irq_q.push_back(irq_n); void'(irq_q.pop_front());
        end
    end

    initial begin
        int rst_hold;
        #2 rst_n = 1'b0;
        #1;
        chk("t6a_async_init", {15'd0, init}, 16'd1);
        chk("t1_rst_vector", vector, 16'hFFFC);
        repeat (2) clk1();
        rst_n = 1'b1;

        // 1: reset sequence
        clk1();
        chk("t1_init_hold", {15'd0, init}, 16'd1);
        vector_load = 1'b1; #1;
        chk("t1_load_vec", vector, 16'hFFFC);
        clk1(); vector_load = 1'b0; seq_done = 1'b1; #1;
        chk("t1_init_done_cycle", {15'd0, init}, 16'd1);
        clk1(); seq_done = 1'b0; #1;
        chk("t1_init_cleared", {15'd0, init}, 16'd0);
        $display("[TB] scenario 1: reset vector sequence");

        // 2: IRQ taken with I=0, ignored with I=1
        irq_n = 1'b0; i_flag = 1'b0;
        repeat (3) clk1();
        seq_start = 1'b1; #1;
        chk("t2_mealy_handle", {15'd0, handle_irq}, 16'd1);
        chk("t2_vector", vector, 16'hFFFE);
        clk1(); seq_start = 1'b0; #1;
        chk("t2_b", {15'd0, b_flag}, 16'd0);
        chk("t2_handle_held", {15'd0, handle_irq}, 16'd1);
        vector_load = 1'b1;
        clk1(); vector_load = 1'b0; seq_done = 1'b1;
        clk1(); seq_done = 1'b0; #1;
        chk("t2_handle_cleared", {15'd0, handle_irq}, 16'd0);
        i_flag = 1'b1; seq_start = 1'b1; #1;
        chk("t2_masked", {15'd0, handle_irq}, 16'd0);
        clk1(); seq_start = 1'b0; #1;
        chk("t2_masked_after", {15'd0, handle_irq}, 16'd0);
        irq_n = 1'b1;
        $display("[TB] scenario 2: IRQ take and mask");

        // 3: NMI one-cycle pulse
        repeat (3) clk1();
        nmi_n = 1'b0;
        clk1(); nmi_n = 1'b1; #1;
        chk("t3_pend_p1", {15'd0, nmi_pending}, 16'd0);
        clk1();
        chk("t3_pend_p2", {15'd0, nmi_pending}, 16'd0);
        clk1();
        chk("t3_pend_p3", {15'd0, nmi_pending}, 16'd1);
        seq_start = 1'b1; #1;
        chk("t3_vector", vector, 16'hFFFA);
        chk("t3_handle", {15'd0, handle_irq}, 16'd1);
        clk1(); seq_start = 1'b0; vector_load = 1'b1; #1;
        chk("t3_pend_at_load", {15'd0, nmi_pending}, 16'd1);
        clk1(); vector_load = 1'b0; #1;
        chk("t3_pend_cleared", {15'd0, nmi_pending}, 16'd0);
        seq_done = 1'b1;
        clk1(); seq_done = 1'b0;
        $display("[TB] scenario 3: NMI edge service");

        // 4: NMI and IRQ at the same boundary
        i_flag = 1'b0; irq_n = 1'b0; nmi_n = 1'b0;
        clk1(); nmi_n = 1'b1;
        repeat (2) clk1();
        seq_start = 1'b1; #1;
        chk("t4_nmi_first", vector, 16'hFFFA);
        clk1(); seq_start = 1'b0; vector_load = 1'b1;
        clk1(); vector_load = 1'b0; seq_done = 1'b1;
        clk1(); seq_done = 1'b0; seq_start = 1'b1; #1;
        chk("t4_irq_second", vector, 16'hFFFE);
        chk("t4_irq_handle", {15'd0, handle_irq}, 16'd1);
        clk1(); seq_start = 1'b0; vector_load = 1'b1;
        clk1(); vector_load = 1'b0; seq_done = 1'b1;
        clk1(); seq_done = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
        repeat (3) clk1();
        $display("[TB] scenario 4: NMI over IRQ priority");

        // 5: BRK with NMI edge before vector load
        brk = 1'b1; seq_start = 1'b1; #1;
        chk("t5_brk_vector", vector, 16'hFFFE);
        chk("t5_brk_no_handle", {15'd0, handle_irq}, 16'd0);
        clk1(); seq_start = 1'b0; brk = 1'b0; #1;
        chk("t5_brk_b", {15'd0, b_flag}, 16'd1);
        nmi_n = 1'b0;
        clk1(); nmi_n = 1'b1;
        repeat (2) clk1();
        chk("t5_pend", {15'd0, nmi_pending}, 16'd1);
        vector_load = 1'b1; #1;
        chk("t5_load_vector", vector, HIJ ? 16'hFFFA : 16'hFFFE);
        clk1(); vector_load = 1'b0; #1;
        chk("t5_pend_after_load", {15'd0, nmi_pending}, {15'd0, !HIJ});
        chk("t5_b_kept", {15'd0, b_flag}, 16'd1);
        seq_done = 1'b1;
        clk1(); seq_done = 1'b0; #1;
        chk("t5_b_cleared", {15'd0, b_flag}, 16'd0);
        seq_start = 1'b1; #1;
        chk("t5_next_vector", vector, 16'hFFFA);
        chk("t5_next_handle", {15'd0, handle_irq}, {15'd0, !HIJ});
        clk1(); seq_start = 1'b0; vector_load = 1'b1;
        clk1(); vector_load = 1'b0; seq_done = 1'b1;
        clk1(); seq_done = 1'b0;
        $display("[TB] scenario 5: BRK with late NMI");

        // 6: reset in the middle of an IRQ service with NMI pending
        irq_n = 1'b0; i_flag = 1'b0;
        repeat (3) clk1();
        seq_start = 1'b1;
        clk1(); seq_start = 1'b0; nmi_n = 1'b0;
        clk1(); nmi_n = 1'b1;
        repeat (2) clk1();
        chk("t6_pend_before", {15'd0, nmi_pending}, 16'd1);
        chk("t6_handle_before", {15'd0, handle_irq}, 16'd1);
        rst_n = 1'b0; #1;
        chk("t6_init", {15'd0, init}, 16'd1);
        chk("t6_handle", {15'd0, handle_irq}, 16'd0);
        chk("t6_vector", vector, 16'hFFFC);
        chk("t6_pend_dropped", {15'd0, nmi_pending}, 16'd0);
        repeat (2) clk1();
        rst_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
        $display("[TB] scenario 6: reset mid service");

        // Randomized traffic against the model
        rst_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            clk1();
            if (rst_hold > 0) begin
                rst_hold--;
                rst_n = (rst_hold == 0);
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                rst_hold = 2;
            end
            if ($urandom_range(0, 9) == 0) irq_n = ~irq_n;
            nmi_n       = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 15) == 0) i_flag = ~i_flag;
            seq_start   = ($urandom_range(0, 4) == 0);
            brk         = ($urandom_range(0, 2) == 0);
            vector_load = ($urandom_range(0, 6) == 0);
            seq_done    = ($urandom_range(0, 6) == 0);
        end
        $display("[TB] random phase: 4000 cycles");
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
